// File: rtl/pe_mac_tree_if.sv
// Beat/result bundle between the ifm/weight feeders, the MAC processing element
// and the output-feature-map buffer.
interface pe_mac_tree_if #(
  parameter int LANES = 4,
  parameter int DW    = 8,
  parameter int ACC_W = 32,
  parameter int CNT_W = 16
);
  logic                    in_valid;
  logic                    in_last;
  logic                    acc_clr;
  logic [LANES*DW-1:0]     ifm_data;
  logic [LANES*DW-1:0]     wgt_data;
  logic                    out_valid;
  logic signed [ACC_W-1:0] out_sum;
  logic                    out_sat;
  logic [CNT_W-1:0]        out_cnt;
  logic                    busy;

  modport master (
    output in_valid, in_last, acc_clr, ifm_data, wgt_data,
    input  out_valid, out_sum, out_sat, out_cnt, busy
  );

  modport slave (
    input  in_valid, in_last, acc_clr, ifm_data, wgt_data,
    output out_valid, out_sum, out_sat, out_cnt, busy
  );
endinterface

// File: rtl/pe_mac_tree.sv
// Multiply-accumulate PE: LANES signed products, pipelined adder tree, and a
// saturating group accumulator that emits one partial sum per in_last group.
module pe_mac_tree #(
  parameter int LANES = 4,
  parameter int DW    = 8,
  parameter int ACC_W = 32,
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  pe_mac_tree_if.slave  bus
);
  localparam int K  = $clog2(LANES);
  localparam int TW = 2*DW + K;
  localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]        CNT_ONE = CNT_W'(1);

  logic signed [2*DW-1:0] prod_c [LANES];
  // Heap layout: leaves LANES..2*LANES-1 hold products, node 1 is the root.
  logic signed [TW-1:0]   tree_q [1:2*LANES-1];
  logic [K:0]             vld_q;
  logic [K:0]             lst_q;

  logic signed [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    sticky_q;
  logic                    out_valid_q;
  logic signed [ACC_W-1:0] out_sum_q;
  logic                    out_sat_q;
  logic [CNT_W-1:0]        out_cnt_q;

  logic [ACC_W:0]          sum_full;
  logic                    ovf;
  logic signed [ACC_W-1:0] acc_next;
  logic [CNT_W-1:0]        cnt_next;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      prod_c[i] = $signed({{DW{bus.ifm_data[i*DW+DW-1]}}, bus.ifm_data[i*DW +: DW]})
                * $signed({{DW{bus.wgt_data[i*DW+DW-1]}}, bus.wgt_data[i*DW +: DW]});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 1; n < 2*LANES; n++) tree_q[n] <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) tree_q[LANES+i] <= TW'(prod_c[i]);
      for (int n = 1; n < LANES; n++) tree_q[n] <= tree_q[2*n] + tree_q[2*n+1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      lst_q <= '0;
    end else if (bus.acc_clr) begin
      vld_q <= '0;
      lst_q <= '0;
    end else begin
      vld_q <= {vld_q[K-1:0], bus.in_valid};
      lst_q <= {lst_q[K-1:0], bus.in_valid & bus.in_last};
    end
  end

  // One guard bit is enough: both addends fit in ACC_W, so the top two bits
  // of the sum disagree exactly when the result leaves the ACC_W range.
  always_comb begin
    sum_full = {acc_q[ACC_W-1], acc_q}
             + {{(ACC_W+1-TW){tree_q[1][TW-1]}}, tree_q[1]};
    ovf      = sum_full[ACC_W] ^ sum_full[ACC_W-1];
    acc_next = sum_full[ACC_W-1:0];
    if (ovf) acc_next = sum_full[ACC_W] ? SAT_MIN : SAT_MAX;
    cnt_next = (&cnt_q) ? cnt_q : cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      sticky_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_sat_q   <= 1'b0;
      out_cnt_q   <= '0;
    end else if (bus.acc_clr) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      sticky_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (vld_q[K]) begin
        if (lst_q[K]) begin
          out_sum_q   <= acc_next;
          out_sat_q   <= sticky_q | ovf;
          out_cnt_q   <= cnt_next;
          out_valid_q <= 1'b1;
          acc_q       <= '0;
          cnt_q       <= '0;
          sticky_q    <= 1'b0;
        end else begin
          acc_q    <= acc_next;
          cnt_q    <= cnt_next;
          sticky_q <= sticky_q | ovf;
        end
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_sat   = out_sat_q;
  assign bus.out_cnt   = out_cnt_q;
  assign bus.busy      = (|vld_q) | (cnt_q != '0);
endmodule

// File: tb/tb_pe_mac_tree.sv
// Directed bench for pe_mac_tree: a default 32-bit accumulator instance and an
// 18-bit instance that share stimulus so saturation can be observed.
module tb_pe_mac_tree;
  localparam int LANES = 4;
  localparam int DW    = 8;
  localparam int CNT_W = 16;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   exp_b2b [8];
  logic [31:0] b2b_ifm [8];
  logic [31:0] b2b_wgt [8];
  logic [31:0] v1234, v5678, vm128, v127;

  pe_mac_tree_if #(.LANES(LANES), .DW(DW), .ACC_W(32), .CNT_W(CNT_W)) bus_main ();
  pe_mac_tree_if #(.LANES(LANES), .DW(DW), .ACC_W(18), .CNT_W(CNT_W)) bus_sat ();

  pe_mac_tree #(.LANES(LANES), .DW(DW), .ACC_W(32), .CNT_W(CNT_W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_main)
  );

  pe_mac_tree #(.LANES(LANES), .DW(DW), .ACC_W(18), .CNT_W(CNT_W)) u_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pack4(input int a0, input int a1, input int a2, input int a3);
    return {a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
  endfunction

  function automatic int dot4(input logic [31:0] a, input logic [31:0] b);
    int s;
    logic signed [7:0] x;
    logic signed [7:0] y;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      x = a[i*8 +: 8];
      y = b[i*8 +: 8];
      s += int'(x) * int'(y);
    end
    return s;
  endfunction

  task automatic setInputs(input logic v, input logic l, input logic c,
                           input logic [31:0] ifm, input logic [31:0] wgt);
    bus_main.in_valid = v;  bus_sat.in_valid = v;
    bus_main.in_last  = l;  bus_sat.in_last  = l;
    bus_main.acc_clr  = c;  bus_sat.acc_clr  = c;
    bus_main.ifm_data = ifm; bus_sat.ifm_data = ifm;
    bus_main.wgt_data = wgt; bus_sat.wgt_data = wgt;
  endtask

  // One cycle: present the beat, let the next rising edge sample it, settle.
  task automatic applyStimulus(input logic v, input logic l, input logic c,
                               input logic [31:0] ifm, input logic [31:0] wgt);
    setInputs(v, l, c, ifm, wgt);
    @(posedge clk);
    #1;
  endtask

  task automatic runIdle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic checkOutput(input string tag, input logic signed [63:0] obs,
                             input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    v1234 = pack4(1, 2, 3, 4);
    v5678 = pack4(5, 6, 7, 8);
    vm128 = pack4(-128, -128, -128, -128);
    v127  = pack4(127, 127, 127, 127);
    for (int j = 0; j < 8; j++) begin
      b2b_ifm[j] = pack4(j + 1, -(j + 2), 3 * j, 127 - j);
      b2b_wgt[j] = pack4(2, j, -1, -(j + 1));
      exp_b2b[j] = dot4(b2b_ifm[j], b2b_wgt[j]);
    end

    setInputs(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] reset state");
    checkOutput("rst_valid", bus_main.out_valid, 0);
    checkOutput("rst_sum",   bus_main.out_sum,   0);
    checkOutput("rst_sat",   bus_main.out_sat,   0);
    checkOutput("rst_cnt",   bus_main.out_cnt,   0);
    checkOutput("rst_busy",  bus_main.busy,      0);
    rst_n = 1'b1;

    $display("[TB] single beat latency");
    applyStimulus(1'b1, 1'b1, 1'b0, v1234, v5678);
    checkOutput("lat_busy0",  bus_main.busy,      1);
    checkOutput("lat_valid0", bus_main.out_valid, 0);
    runIdle(1);
    checkOutput("lat_busy1",  bus_main.busy,      1);
    checkOutput("lat_valid1", bus_main.out_valid, 0);
    runIdle(1);
    checkOutput("lat_busy2",  bus_main.busy,      1);
    checkOutput("lat_valid2", bus_main.out_valid, 0);
    runIdle(1);
    checkOutput("lat_valid3", bus_main.out_valid, 1);
    checkOutput("lat_sum",    bus_main.out_sum,   70);
    checkOutput("lat_cnt",    bus_main.out_cnt,   1);
    checkOutput("lat_sat",    bus_main.out_sat,   0);
    checkOutput("lat_busy3",  bus_main.busy,      0);
    runIdle(1);
    checkOutput("hold_valid", bus_main.out_valid, 0);
    checkOutput("hold_sum",   bus_main.out_sum,   70);

    $display("[TB] signed extremes");
    applyStimulus(1'b1, 1'b0, 1'b0, vm128, vm128);
    applyStimulus(1'b1, 1'b0, 1'b0, vm128, vm128);
    applyStimulus(1'b1, 1'b1, 1'b0, vm128, vm128);
    runIdle(3);
    checkOutput("ext_valid", bus_main.out_valid, 1);
    checkOutput("ext_sum",   bus_main.out_sum,   196608);
    checkOutput("ext_cnt",   bus_main.out_cnt,   3);
    checkOutput("ext_sat",   bus_main.out_sat,   0);
    checkOutput("sat18_sum", bus_sat.out_sum,    131071);
    checkOutput("sat18_sat", bus_sat.out_sat,    1);
    checkOutput("sat18_cnt", bus_sat.out_cnt,    3);
    applyStimulus(1'b1, 1'b1, 1'b0, vm128, v127);
    runIdle(3);
    checkOutput("neg_valid", bus_main.out_valid, 1);
    checkOutput("neg_sum",   bus_main.out_sum,   -65024);
    checkOutput("neg_cnt",   bus_main.out_cnt,   1);
    checkOutput("neg18_sat", bus_sat.out_sat,    0);
    applyStimulus(1'b1, 1'b1, 1'b0, v1234, v5678);
    runIdle(3);
    checkOutput("fresh18_sum", bus_sat.out_sum, 70);
    checkOutput("fresh18_sat", bus_sat.out_sat, 0);

    $display("[TB] bubbles");
    applyStimulus(1'b1, 1'b0, 1'b0, v1234, v5678);
    applyStimulus(1'b1, 1'b1, 1'b0, v1234, v5678);
    runIdle(3);
    checkOutput("cont_valid", bus_main.out_valid, 1);
    checkOutput("cont_sum",   bus_main.out_sum,   140);
    checkOutput("cont_cnt",   bus_main.out_cnt,   2);
    runIdle(1);
    checkOutput("cont_once",  bus_main.out_valid, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, v1234, v5678);
    runIdle(5);
    checkOutput("gap_valid",  bus_main.out_valid, 0);
    checkOutput("gap_busy",   bus_main.busy,      1);
    applyStimulus(1'b1, 1'b1, 1'b0, v1234, v5678);
    runIdle(3);
    checkOutput("gap_valid2", bus_main.out_valid, 1);
    checkOutput("gap_sum",    bus_main.out_sum,   140);
    checkOutput("gap_cnt",    bus_main.out_cnt,   2);

    $display("[TB] back-to-back");
    for (int j = 0; j < 8; j++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, b2b_ifm[j], b2b_wgt[j]);
      if (j >= 3) begin
        checkOutput($sformatf("b2b_valid%0d", j - 3), bus_main.out_valid, 1);
        checkOutput($sformatf("b2b_sum%0d", j - 3),   bus_main.out_sum,   exp_b2b[j-3]);
        checkOutput($sformatf("b2b_cnt%0d", j - 3),   bus_main.out_cnt,   1);
      end
    end
    for (int j = 5; j < 8; j++) begin
      runIdle(1);
      checkOutput($sformatf("b2b_valid%0d", j), bus_main.out_valid, 1);
      checkOutput($sformatf("b2b_sum%0d", j),   bus_main.out_sum,   exp_b2b[j]);
    end

    $display("[TB] flush");
    applyStimulus(1'b1, 1'b0, 1'b0, v1234, v5678);
    applyStimulus(1'b1, 1'b1, 1'b0, v1234, v5678);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
    checkOutput("clr_busy",   bus_main.busy,      0);
    checkOutput("clr_valid0", bus_main.out_valid, 0);
    runIdle(2);
    checkOutput("clr_valid1", bus_main.out_valid, 0);
    checkOutput("clr_hold",   bus_main.out_sum,   exp_b2b[7]);
    applyStimulus(1'b1, 1'b1, 1'b1, v1234, v5678);
    runIdle(3);
    checkOutput("clr_same_valid", bus_main.out_valid, 0);
    checkOutput("clr_same_busy",  bus_main.busy,      0);
    applyStimulus(1'b1, 1'b1, 1'b0, v1234, v5678);
    runIdle(2);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
    checkOutput("clr_race_valid", bus_main.out_valid, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, v1234, v5678);
    runIdle(3);
    checkOutput("post_clr_valid", bus_main.out_valid, 1);
    checkOutput("post_clr_sum",   bus_main.out_sum,   70);
    checkOutput("post_clr_cnt",   bus_main.out_cnt,   1);

    $display("[TB] reset mid-group");
    applyStimulus(1'b1, 1'b0, 1'b0, v1234, v5678);
    applyStimulus(1'b1, 1'b0, 1'b0, v1234, v5678);
    applyStimulus(1'b1, 1'b1, 1'b0, v1234, v5678);
    setInputs(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_sum",   bus_main.out_sum,   0);
    checkOutput("arst_cnt",   bus_main.out_cnt,   0);
    checkOutput("arst_valid", bus_main.out_valid, 0);
    checkOutput("arst_busy",  bus_main.busy,      0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("arst_nopulse%0d", i), bus_main.out_valid, 0);
      runIdle(1);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, v1234, v5678);
    runIdle(3);
    checkOutput("post_rst_valid", bus_main.out_valid, 1);
    checkOutput("post_rst_sum",   bus_main.out_sum,   70);
    checkOutput("post_rst_cnt",   bus_main.out_cnt,   1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
